// File: rtl/tile_spawner.sv
// tile_spawner: after each committed move, places a "2" or "4" tile in a
// random empty cell of the 4x4 board. The LFSR value picks the starting cell,
// and the scan wraps around a snapshot of the board taken when the request is
// accepted. The block then issues one write and pulses done, or pulses full
// when no cell is empty.
module tile_spawner #(
  parameter int CELLS    = 16,
  parameter int CELL_W   = 4,
  parameter int FOUR_MIN = 14
) (
  input  logic                    CLK100MHZ,
  input  logic                    CPU_RESET,
  input  logic                    spawn_req,
  input  logic [CELLS*CELL_W-1:0] board,
  input  logic [3:0]              rnd,
  output logic                    busy,
  output logic                    wr_en,
  output logic [3:0]              wr_idx,
  output logic [CELL_W-1:0]       wr_val,
  output logic                    done,
  output logic                    full
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    FULL  = 3'd4
  } state_t;

  localparam logic [3:0]        FOUR_MIN_RND = 4'(FOUR_MIN);
  localparam logic [CELL_W-1:0] EXP_TWO      = CELL_W'(1);
  localparam logic [CELL_W-1:0] EXP_FOUR     = CELL_W'(2);
  localparam logic [3:0]        LAST_CNT     = 4'(CELLS - 1);

  state_t                  state;
  logic [CELLS*CELL_W-1:0] snap;     // board as it was when the request was accepted
  logic [3:0]              idx;      // cell under examination; wraps 15 -> 0
  logic [3:0]              cnt;      // cells already examined and found occupied
  logic [CELL_W-1:0]       cur_cell;
  logic                    cur_empty;

  // Select the snapshot cell currently addressed by idx.
  // NOTE: every signal written in always_comb is assigned on every path, so no latch is inferred.
  always_comb begin
    cur_cell  = snap[int'(idx) * CELL_W +: CELL_W];
    cur_empty = (cur_cell == '0);
  end

  // Spawn sequencer. Outputs are registered alongside the state, so wr_en,
  // done and full are high exactly while the FSM is in WRITE, DONE and FULL.
  // wr_idx doubles as the selected-cell register and stays put outside WRITE.
  always_ff @(posedge CLK100MHZ) begin
    // NOTE: synchronous reset; the snapshot is a plain register and is cleared with everything else.
    if (CPU_RESET) begin
      state  <= IDLE;
      busy   <= 1'b0;
      wr_en  <= 1'b0;
      done   <= 1'b0;
      full   <= 1'b0;
      wr_idx <= '0;
      wr_val <= '0;
      snap   <= '0;
      idx    <= '0;
      cnt    <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout; the default pulse clears below are overridden later in the block.
      wr_en <= 1'b0;
      done  <= 1'b0;
      full  <= 1'b0;
      case (state)
        IDLE: begin
          if (spawn_req) begin
            snap  <= board;
            idx   <= rnd;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (cur_empty) begin
            wr_idx <= idx;
            wr_val <= (rnd >= FOUR_MIN_RND) ? EXP_FOUR : EXP_TWO;
            wr_en  <= 1'b1;
            state  <= WRITE;
          end else if (cnt == LAST_CNT) begin
            full  <= 1'b1;
            state <= FULL;
          end else begin
            idx <= idx + 4'd1;
            cnt <= cnt + 4'd1;
          end
        end
        WRITE: begin
          done  <= 1'b1;
          state <= DONE;
        end
        DONE, FULL: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tile_spawner.sv
// tb_tile_spawner: directed and random spawns, checked against a reference
// model that finds the first empty cell in wrap-around order starting at the
// accepted rnd value and derives the whole pulse timeline from that position.
module tb_tile_spawner;

  localparam logic [63:0] ALL_ONES = {16{4'h1}};

  logic        clk = 1'b0;
  logic        rst;
  logic        spawn_req;
  logic [63:0] board;
  logic [3:0]  rnd;
  logic        busy;
  logic        wr_en;
  logic [3:0]  wr_idx;
  logic [3:0]  wr_val;
  logic        done;
  logic        full;

  int total = 0;
  int bad   = 0;

  tile_spawner #(.CELLS(16), .CELL_W(4), .FOUR_MIN(14)) dut (
    .CLK100MHZ (clk),
    .CPU_RESET (rst),
    .spawn_req (spawn_req),
    .board     (board),
    .rnd       (rnd),
    .busy      (busy),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_val    (wr_val),
    .done      (done),
    .full      (full)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Global time limit so the bench always terminates.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " busy"},  busy,  0);
    check({tag, " wr_en"}, wr_en, 0);
    check({tag, " done"},  done,  0);
    check({tag, " full"},  full,  0);
  endtask

  // One spawn request from an idle block. r_sel >= 0 forces rnd on the edge
  // where the empty cell is found; clobber overwrites the board after accept;
  // toggle wiggles spawn_req while busy.
  task automatic spawn(input string name, input logic [63:0] b, input logic [3:0] r0,
                       input int r_sel, input bit clobber, input bit toggle);
    logic [3:0] rh [0:20];
    bit         is_full;
    int         k;
    int         last;
    int         nwr;
    logic [3:0] exp_idx;
    logic [3:0] exp_val;
    rh[0] = r0;
    for (int j = 1; j <= 20; j++) rh[j] = 4'($urandom_range(1, 15));
    // Reference: first empty cell in order r0, r0+1, ... modulo 16.
    is_full = 1'b1;
    k       = 0;
    for (int i = 0; i < 16; i++) begin
      if (is_full && b[((int'(r0) + i) % 16) * 4 +: 4] == 4'd0) begin
        is_full = 1'b0;
        k       = i;
      end
    end
    if (!is_full && r_sel >= 0) rh[k + 1] = 4'(r_sel);
    exp_idx = 4'((int'(r0) + k) % 16);
    exp_val = (rh[k + 1] >= 4'd14) ? 4'd2 : 4'd1;
    last    = is_full ? 17 : k + 3;
    nwr     = 0;

    board     = b;
    spawn_req = 1'b1;
    rnd       = rh[0];
    for (int j = 0; j <= last; j++) begin
      @(posedge clk);
      #1;
      if (wr_en) nwr++;
      check($sformatf("%s busy@%0d", name, j),  busy,  (j < last) ? 1 : 0);
      check($sformatf("%s wr_en@%0d", name, j), wr_en, (!is_full && j == k + 1) ? 1 : 0);
      check($sformatf("%s done@%0d", name, j),  done,  (!is_full && j == k + 2) ? 1 : 0);
      check($sformatf("%s full@%0d", name, j),  full,  (is_full && j == 16) ? 1 : 0);
      if (!is_full && j == k + 1) begin
        check({name, " wr_idx"}, wr_idx, exp_idx);
        check({name, " wr_val"}, wr_val, exp_val);
      end
      spawn_req = toggle && (j < last) && (j % 2 == 0);
      rnd       = rh[j + 1];
      if (clobber && j == 0) board = ALL_ONES;
    end
    // Requests seen while busy must not have been queued.
    for (int j = 0; j < 3; j++) begin
      @(posedge clk);
      #1;
      if (wr_en) nwr++;
      check_idle_outputs($sformatf("%s after@%0d", name, j));
    end
    check({name, " write count"}, nwr, is_full ? 0 : 1);
    if (!is_full) begin
      check({name, " wr_idx held"}, wr_idx, exp_idx);
      check({name, " wr_val held"}, wr_val, exp_val);
    end
  endtask

  initial begin
    logic [63:0] rb;
    int          thr;
    rst       = 1'b1;
    spawn_req = 1'b0;
    board     = '0;
    rnd       = 4'd1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle_outputs("reset");
    check("reset wr_idx", wr_idx, 0);
    check("reset wr_val", wr_val, 0);

    // T2: empty board, start at 5, "2" tile.
    spawn("t2_empty", 64'h0, 4'd5, 3, 1'b0, 1'b0);
    // T3: only cell 0 empty, start at 15: wraps to 0.
    spawn("t3_wrap", ALL_ONES & ~64'hF, 4'd15, -1, 1'b0, 1'b0);
    // T4: "4" tile on rnd=14 at the select edge.
    spawn("t4_four", 64'h0, 4'd7, 14, 1'b0, 1'b0);
    // T5: full board.
    spawn("t5_full", ALL_ONES, 4'd9, -1, 1'b0, 1'b0);
    // T6: board clobbered after accept, and spawn_req toggled while busy.
    spawn("t6_snap", 64'h0, 4'd11, -1, 1'b1, 1'b0);
    spawn("t6_toggle", ALL_ONES & ~(64'hF << 12), 4'd2, -1, 1'b0, 1'b1);

    // T1: reset for two cycles in the middle of a long scan.
    board     = ALL_ONES;
    spawn_req = 1'b1;
    rnd       = 4'd9;
    @(posedge clk);
    #1;
    spawn_req = 1'b0;
    check("t1 busy before reset", busy, 1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle_outputs("t1 reset");
    check("t1 reset wr_idx", wr_idx, 0);
    repeat (20) begin
      @(posedge clk);
      #1;
      check_idle_outputs("t1 post");
    end

    // Reset on the edge that would have raised wr_en: no write afterwards.
    board     = 64'h0;
    spawn_req = 1'b1;
    rnd       = 4'd4;
    @(posedge clk);
    #1;
    spawn_req = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle_outputs("wr_reset");
    repeat (4) begin
      @(posedge clk);
      #1;
      check_idle_outputs("wr_reset post");
    end

    // Random boards of varying occupancy, random start, random request behaviour.
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 3))
        0:       thr = 8;
        1:       thr = 3;
        2:       thr = 1;
        default: thr = 0;
      endcase
      for (int c = 0; c < 16; c++) begin
        if (int'($urandom_range(0, 15)) < thr) rb[c * 4 +: 4] = 4'd0;
        else                                   rb[c * 4 +: 4] = 4'($urandom_range(1, 11));
      end
      spawn($sformatf("rand%0d", n), rb, 4'($urandom_range(1, 15)), -1,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
